// File: rtl/pulse_stretch_pkg.sv
// Shared types and parameter-range limits for the pulse stretcher.
// Macro PULSE_STRETCH_RETRIG_EN (see pulse_stretch.sv) selects retrigger behaviour.
package pulse_stretch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    localparam int CW_MIN      = 1;
    localparam int CW_MAX      = 31;
    localparam int PULSE_MIN   = 1;
    localparam int HOLDOFF_MIN = 0;

    // Largest value a cw-bit down-counter can be loaded with.
    function automatic longint max_count(input int cw);
        return (longint'(1) << cw) - longint'(1);
    endfunction

endpackage

// File: rtl/pulse_stretch_ctr.sv
// Loadable down-counter with zero detect; decrement saturates at zero.
module pulse_stretch_ctr #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] loadval,
    input  logic          dec,
    output logic          zero
);

    logic [CW-1:0] cnt;

    // Load wins over decrement so the FSM can reload in any cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= loadval;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pulse_stretch.sv
// Trigger-to-pulse stretcher with optional hold-off dead time.
// Define PULSE_STRETCH_RETRIG_EN to let a trigger during the pulse restart it.
module pulse_stretch
    import pulse_stretch_pkg::*;
#(
    parameter int   CW      = 8,
    parameter int   PULSE   = 10,
    parameter int   HOLDOFF = 0,
    parameter logic ACTLVL  = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic clken,
    input  logic trig,
    input  logic clr,
    output logic o,
    output logic busy,
    output logic ovr
);

    if ((CW < CW_MIN) || (CW > CW_MAX)) begin : g_bad_cw
        $error("pulse_stretch: CW out of range");
    end
    if ((PULSE < PULSE_MIN) || (longint'(PULSE) > max_count(CW))) begin : g_bad_pulse
        $error("pulse_stretch: PULSE out of range");
    end
    if ((HOLDOFF < HOLDOFF_MIN) || (longint'(HOLDOFF) > max_count(CW))) begin : g_bad_holdoff
        $error("pulse_stretch: HOLDOFF out of range");
    end

    localparam logic [CW-1:0] PULSE_LD = CW'(PULSE - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLDOFF - 1);
    localparam bit            HAS_HOLD = (HOLDOFF > 0);

    state_t        state;
    state_t        state_n;
    logic          ld;
    logic [CW-1:0] ldval;
    logic          dec;
    logic          zero;
    logic          o_n;
    logic          ovr_n;

    pulse_stretch_ctr #(
        .CW(CW)
    ) u_ctr (
        .clk    (clk),
        .rst    (rst),
        .load   (ld),
        .loadval(ldval),
        .dec    (dec),
        .zero   (zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            o     <= ~ACTLVL;
            ovr   <= 1'b0;
        end else begin
            state <= state_n;
            o     <= o_n;
            ovr   <= ovr_n;
        end
    end

    // Exit from ACTIVE/HOLDOFF needs clken; trig is looked at every edge.
    always_comb begin
        state_n = state;
        ld      = 1'b0;
        ldval   = '0;
        dec     = 1'b0;
        ovr_n   = 1'b0;
        if (clr) begin
            state_n = ST_IDLE;
            ld      = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (trig) begin
                        state_n = ST_ACTIVE;
                        ld      = 1'b1;
                        ldval   = PULSE_LD;
                    end
                end
                ST_ACTIVE: begin
`ifdef PULSE_STRETCH_RETRIG_EN
                    if (trig) begin
                        ld    = 1'b1;
                        ldval = PULSE_LD;
                    end else if (clken) begin
`else
                    ovr_n = trig;
                    if (clken) begin
`endif
                        if (!zero) begin
                            dec = 1'b1;
                        end else if (HAS_HOLD) begin
                            state_n = ST_HOLDOFF;
                            ld      = 1'b1;
                            ldval   = HOLD_LD;
                        end else begin
                            state_n = ST_IDLE;
                        end
                    end
                end
                ST_HOLDOFF: begin
                    ovr_n = trig;
                    if (clken) begin
                        if (!zero) begin
                            dec = 1'b1;
                        end else begin
                            state_n = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    ld      = 1'b1;
                end
            endcase
        end
        o_n = (state_n == ST_ACTIVE) ? ACTLVL : ~ACTLVL;
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_pulse_stretch.sv
// Directed bench for pulse_stretch with PULSE=4, HOLDOFF=2, ACTLVL=1.
module tb_pulse_stretch;

    logic clk;
    logic rst;
    logic clken;
    logic trig;
    logic clr;
    logic o;
    logic busy;
    logic ovr;

    int vectors;
    int miscompares;

`ifdef PULSE_STRETCH_RETRIG_EN
    localparam bit RT = 1'b1;
`else
    localparam bit RT = 1'b0;
`endif

    typedef struct {
        logic ce;
        logic tr;
        logic cl;
        logic eo;
        logic eb;
        logic ev;
    } vec_t;

    vec_t basic[15];

    pulse_stretch #(
        .CW     (8),
        .PULSE  (4),
        .HOLDOFF(2),
        .ACTLVL (1'b1)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .clken(clken),
        .trig (trig),
        .clr  (clr),
        .o    (o),
        .busy (busy),
        .ovr  (ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic eo, input logic eb, input logic ev);
        vectors++;
        if ({o, busy, ovr} !== {eo, eb, ev}) begin
            miscompares++;
            $display("[TB] FAIL %s: got o/busy/ovr=%b%b%b expected %b%b%b",
                     name, o, busy, ovr, eo, eb, ev);
        end
    endtask

    task automatic applyStimulus(input logic ce, input logic tr, input logic cl);
        clken = ce;
        trig  = tr;
        clr   = cl;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string name, input logic ce, input logic tr, input logic cl,
                        input logic eo, input logic eb, input logic ev);
        checkOutput(name, eo, eb, ev);
        applyStimulus(ce, tr, cl);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst   = 1'b1;
        clken = 1'b1;
        trig  = 1'b0;
        clr   = 1'b0;

        // One row per cycle: inputs driven in that cycle, outputs expected in it.
        basic[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        basic[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        basic[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        basic[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        basic[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        basic[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        basic[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        basic[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        basic[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        basic[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        basic[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        basic[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        basic[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        basic[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        basic[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset held with trig pulsing, then released mid-cycle.
        #1;
        for (int i = 0; i < 3; i++) begin
            step("reset_hold", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        checkOutput("reset_hold", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step("reset_idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // First trig right after a fresh reset release must be accepted.
        rst = 1'b1;
        #1;
        checkOutput("reset_async", 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] basic pulse table");
        for (int i = 0; i < 15; i++) begin
            step($sformatf("basic_c%0d", i), basic[i].ce, basic[i].tr, basic[i].cl,
                 basic[i].eo, basic[i].eb, basic[i].ev);
        end

        $display("[TB] second trig in active");
        step("retrig_c0", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("retrig_c1", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step("retrig_c2", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step("retrig_c3", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, !RT);
        step("retrig_c4", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step("retrig_c5", 1'b1, 1'b0, 1'b0, RT,   1'b1, 1'b0);
        step("retrig_c6", 1'b1, 1'b0, 1'b0, RT,   1'b1, 1'b0);
        step("retrig_c7", 1'b1, 1'b0, 1'b0, 1'b0, RT,   1'b0);
        step("retrig_c8", 1'b1, 1'b0, 1'b0, 1'b0, RT,   1'b0);
        step("retrig_c9", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] clken on odd cycles");
        step("clken_c0", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c < 8; c++) begin
            step($sformatf("clken_c%0d", c), logic'(c % 2), 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        end
        for (int c = 8; c < 12; c++) begin
            step($sformatf("clken_c%0d", c), logic'(c % 2), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        step("clken_c12", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] clr with trig");
        step("clr_c0", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("clr_c1", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step("clr_c2", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step("clr_c3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("clr_c4", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int c = 5; c < 8; c++) begin
            step($sformatf("clr_c%0d", c), 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        end
        step("clr_c8", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("clr_c9", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("clr_c10", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] async reset in holdoff");
        step("arst_c0", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c < 5; c++) begin
            step($sformatf("arst_c%0d", c), 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        end
        checkOutput("arst_c5_pre", 1'b0, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_c5_post", 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("arst_after", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("arst_trig", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
